lzx_shift_ctrl: RTL



---
 rtl/lzx_shift_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lzx_shift_ctrl.sv
// Sequencer/arbiter sharing one 4-bit 194-style universal shift register between a TX and an RX requester.
// Optional LZX_SHIFT_CTRL_RR_EN selects round-robin tie-breaking; otherwise TX wins ties.
module lzx_shift_ctrl (
    input  logic       CLK,
    input  logic       MR,
    input  logic       tx_req,
    input  logic [3:0] tx_data,
    output logic       tx_ack,
    output logic       ser_out,
    output logic       ser_valid,
    input  logic       rx_req,
    input  logic       rx_bit,
    output logic       rx_ready,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic [1:0] S,
    output logic [3:0] D,
    output logic       DSR,
    output logic       DSL,
    input  logic [3:0] Q
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_LOAD  = 3'd1,
        TX_SHIFT = 3'd2,
        RX_SHIFT = 3'd3,
        RX_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] txbuf_q, txbuf_d;
    logic       last_grant_q, last_grant_d;

    logic [1:0] s_q, s_d;
    logic [3:0] d_q, d_d;
    logic       tx_ack_q, tx_ack_d;
    logic       ser_valid_q, ser_valid_d;
    logic       rx_ready_q, rx_ready_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;

    logic       grant_rx;

    // On a tie, round-robin hands the grant to whoever did not win last time.
    always_comb begin
`ifdef LZX_SHIFT_CTRL_RR_EN
        grant_rx = rx_req && (!tx_req || !last_grant_q);
`else
        grant_rx = rx_req && !tx_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        txbuf_d      = txbuf_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_rx) begin
                    cnt_d        = 2'd0;
                    last_grant_d = 1'b1;
                    state_d      = RX_SHIFT;
                end else if (tx_req) begin
                    txbuf_d      = tx_data;
                    last_grant_d = 1'b0;
                    state_d      = TX_LOAD;
                end
            end
            TX_LOAD: begin
                cnt_d   = 2'd0;
                state_d = TX_SHIFT;
            end
            TX_SHIFT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            RX_SHIFT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = RX_DONE;
                end
            end
            RX_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        s_d         = MODE_HOLD;
        d_d         = 4'b0000;
        tx_ack_d    = 1'b0;
        ser_valid_d = 1'b0;
        rx_ready_d  = 1'b0;
        rx_valid_d  = 1'b0;
        busy_d      = (state_d != IDLE);
        case (state_d)
            TX_LOAD: begin
                s_d      = MODE_LOAD;
                d_d      = txbuf_d;
                tx_ack_d = 1'b1;
            end
            TX_SHIFT: begin
                s_d         = MODE_RIGHT;
                ser_valid_d = 1'b1;
            end
            RX_SHIFT: begin
                s_d        = MODE_LEFT;
                rx_ready_d = 1'b1;
            end
            RX_DONE: begin
                rx_valid_d = 1'b1;
            end
            default: begin
                s_d = MODE_HOLD;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            txbuf_q      <= 4'b0000;
            last_grant_q <= 1'b1;
            s_q          <= MODE_HOLD;
            d_q          <= 4'b0000;
            tx_ack_q     <= 1'b0;
            ser_valid_q  <= 1'b0;
            rx_ready_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            txbuf_q      <= txbuf_d;
            last_grant_q <= last_grant_d;
            s_q          <= s_d;
            d_q          <= d_d;
            tx_ack_q     <= tx_ack_d;
            ser_valid_q  <= ser_valid_d;
            rx_ready_q   <= rx_ready_d;
            rx_valid_q   <= rx_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Q and rx_bit pass straight through, gated by the registered qualifiers.
    assign S         = s_q;
    assign D         = d_q;
    assign tx_ack    = tx_ack_q;
    assign ser_valid = ser_valid_q;
    assign ser_out   = ser_valid_q & Q[0];
    assign rx_ready  = rx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_valid_q ? Q : 4'b0000;
    assign busy      = busy_q;
    assign DSR       = 1'b0;
    assign DSL       = rx_ready_q & rx_bit;

endmodule
